// File: rtl/ctrl_pipe_regs_pkg.sv
// Shared control-word definitions for the decoder and the ID/EX/MEM/WB control pipeline.
package ctrl_pipe_regs_pkg;

  localparam int REG_W      = 5;
  localparam int ALU_OP_W   = 4;
  localparam int SOH_W      = 4;
  localparam int RAM_SIZE_W = 2;
  localparam int LCJ_W      = 2;

  localparam int IMM_W_DEF = 32;
  localparam int KW_W_DEF  = 80;
  localparam int CNT_W_DEF = 16;

  // Writeback source select carried in the lcj field
  localparam logic [LCJ_W-1:0] LCJ_ALU  = 2'b00;
  localparam logic [LCJ_W-1:0] LCJ_LOAD = 2'b01;
  localparam logic [LCJ_W-1:0] LCJ_CALL = 2'b10;
  localparam logic [LCJ_W-1:0] LCJ_JMPL = 2'b11;

  // ASCII "nop", right-justified and zero padded
  localparam logic [KW_W_DEF-1:0] KW_NOP = 80'h6e6f70;

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline stage register: holds when en=0, loads the bubble value on bubble or reset.
import ctrl_pipe_regs_pkg::*;

module ctrl_stage_reg #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         bubble,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= bubble ? RST_VAL : d;
    end
  end

endmodule

// File: rtl/ctrl_pipe_regs.sv
// Control-word pipeline from ID to WB with load-use stall, flush bubbles and perf counters.
import ctrl_pipe_regs_pkg::*;

module ctrl_pipe_regs #(
  parameter int IMM_W = IMM_W_DEF,
  parameter int KW_W  = KW_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  LE,
  input  logic                  flush,
  input  logic [ALU_OP_W-1:0]   id_alu_op,
  input  logic [SOH_W-1:0]      id_soh_s,
  input  logic                  id_alu_src,
  input  logic                  id_psr_en,
  input  logic                  id_rf_le,
  input  logic                  id_load,
  input  logic [RAM_SIZE_W-1:0] id_ram_size,
  input  logic                  id_ram_rw,
  input  logic                  id_ram_en,
  input  logic [LCJ_W-1:0]      id_lcj,
  input  logic                  id_mem_to_reg,
  input  logic                  id_call,
  input  logic                  id_jmpl,
  input  logic [REG_W-1:0]      id_rs1,
  input  logic [REG_W-1:0]      id_rs2,
  input  logic [REG_W-1:0]      id_rd,
  input  logic [IMM_W-1:0]      id_imm,
  input  logic [KW_W-1:0]       id_kw,
  output logic [ALU_OP_W-1:0]   ex_alu_op,
  output logic [SOH_W-1:0]      ex_soh_s,
  output logic                  ex_alu_src,
  output logic                  ex_psr_en,
  output logic                  ex_rf_le,
  output logic                  ex_load,
  output logic [RAM_SIZE_W-1:0] ex_ram_size,
  output logic                  ex_ram_rw,
  output logic                  ex_ram_en,
  output logic [LCJ_W-1:0]      ex_lcj,
  output logic                  ex_mem_to_reg,
  output logic                  ex_call,
  output logic                  ex_jmpl,
  output logic [REG_W-1:0]      ex_rs1,
  output logic [REG_W-1:0]      ex_rs2,
  output logic [REG_W-1:0]      ex_rd,
  output logic [IMM_W-1:0]      ex_imm,
  output logic [KW_W-1:0]       ex_kw,
  output logic                  mem_rf_le,
  output logic [REG_W-1:0]      mem_rd,
  output logic [RAM_SIZE_W-1:0] mem_ram_size,
  output logic                  mem_ram_rw,
  output logic                  mem_ram_en,
  output logic                  mem_load,
  output logic [LCJ_W-1:0]      mem_lcj,
  output logic                  mem_mem_to_reg,
  output logic [KW_W-1:0]       mem_kw,
  output logic                  wb_rf_le,
  output logic [REG_W-1:0]      wb_rd,
  output logic [LCJ_W-1:0]      wb_lcj,
  output logic                  wb_mem_to_reg,
  output logic [KW_W-1:0]       wb_kw,
  output logic                  stall_if,
  output logic [CNT_W-1:0]      cnt_retired,
  output logic [CNT_W-1:0]      cnt_bubbles
);

  localparam int IDEX_W  = 1 + ALU_OP_W + SOH_W + 4 + RAM_SIZE_W + 2 + LCJ_W + 3
                           + 3*REG_W + IMM_W + KW_W;
  localparam int EXMEM_W = 2 + REG_W + RAM_SIZE_W + 3 + LCJ_W + 1 + KW_W;
  localparam int MEMWB_W = 2 + REG_W + LCJ_W + 1 + KW_W;

  // kw sits in the low bits, so zero-extending the "nop" tag yields the whole bubble word
  localparam logic [KW_W-1:0]    KW_BUB    = KW_W'(KW_NOP);
  localparam logic [IDEX_W-1:0]  IDEX_BUB  = IDEX_W'(KW_BUB);
  localparam logic [EXMEM_W-1:0] EXMEM_BUB = EXMEM_W'(KW_BUB);
  localparam logic [MEMWB_W-1:0] MEMWB_BUB = MEMWB_W'(KW_BUB);

  logic                ex_valid, mem_valid, wb_valid;
  logic                wb_rf_le_raw;
  logic                hazard, id_bubble;
  logic [IDEX_W-1:0]   idex_d, idex_q;
  logic [EXMEM_W-1:0]  exmem_d, exmem_q;
  logic [MEMWB_W-1:0]  memwb_d, memwb_q;

  // Flow control: LE=0 freezes every stage. With LE=1 the ID word is taken unless
  // flush or a load-use hazard turns it into a bubble; on a hazard stall_if holds
  // fetch so the same ID word is presented again next cycle.
  assign hazard = ex_valid & ex_load & ex_rf_le & (ex_rd != '0) &
                  ((ex_rd == id_rs1) |
                   ((ex_rd == id_rs2) & ~id_alu_src) |
                   ((ex_rd == id_rd) & id_ram_en & id_ram_rw));
  assign id_bubble = flush | hazard;
  assign stall_if  = hazard & LE & ~flush;

  assign idex_d = {1'b1, id_alu_op, id_soh_s, id_alu_src, id_psr_en, id_rf_le, id_load,
                   id_ram_size, id_ram_rw, id_ram_en, id_lcj, id_mem_to_reg, id_call,
                   id_jmpl, id_rs1, id_rs2, id_rd, id_imm, id_kw};
  assign {ex_valid, ex_alu_op, ex_soh_s, ex_alu_src, ex_psr_en, ex_rf_le, ex_load,
          ex_ram_size, ex_ram_rw, ex_ram_en, ex_lcj, ex_mem_to_reg, ex_call, ex_jmpl,
          ex_rs1, ex_rs2, ex_rd, ex_imm, ex_kw} = idex_q;

  assign exmem_d = {ex_valid, ex_rf_le, ex_rd, ex_ram_size, ex_ram_rw, ex_ram_en, ex_load,
                    ex_lcj, ex_mem_to_reg, ex_kw};
  assign {mem_valid, mem_rf_le, mem_rd, mem_ram_size, mem_ram_rw, mem_ram_en, mem_load,
          mem_lcj, mem_mem_to_reg, mem_kw} = exmem_q;

  assign memwb_d = {mem_valid, mem_rf_le, mem_rd, mem_lcj, mem_mem_to_reg, mem_kw};
  assign {wb_valid, wb_rf_le_raw, wb_rd, wb_lcj, wb_mem_to_reg, wb_kw} = memwb_q;

  // r0 is hardwired, so a write to it never reaches the register file
  assign wb_rf_le = wb_rf_le_raw & (wb_rd != '0);

  ctrl_stage_reg #(.W(IDEX_W), .RST_VAL(IDEX_BUB)) u_id_ex (
    .clk(clk), .reset(reset), .en(LE), .bubble(id_bubble), .d(idex_d), .q(idex_q)
  );

  ctrl_stage_reg #(.W(EXMEM_W), .RST_VAL(EXMEM_BUB)) u_ex_mem (
    .clk(clk), .reset(reset), .en(LE), .bubble(1'b0), .d(exmem_d), .q(exmem_q)
  );

  ctrl_stage_reg #(.W(MEMWB_W), .RST_VAL(MEMWB_BUB)) u_mem_wb (
    .clk(clk), .reset(reset), .en(LE), .bubble(1'b0), .d(memwb_d), .q(memwb_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_retired <= '0;
      cnt_bubbles <= '0;
    end else if (LE) begin
      if (id_bubble) cnt_bubbles <= cnt_bubbles + CNT_W'(1);
      if (wb_valid)  cnt_retired <= cnt_retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ctrl_pipe_regs.sv
// Directed bench for ctrl_pipe_regs with a WB-stage scoreboard fed by the stimulus.
module tb_ctrl_pipe_regs;

  localparam int EXP_W = 80 + 5 + 1 + 2 + 1;
  localparam logic [79:0] NOP = 80'h6e6f70;

  logic        clk = 1'b0;
  logic        reset, LE, flush;
  logic [3:0]  id_alu_op, id_soh_s;
  logic        id_alu_src, id_psr_en, id_rf_le, id_load;
  logic [1:0]  id_ram_size;
  logic        id_ram_rw, id_ram_en;
  logic [1:0]  id_lcj;
  logic        id_mem_to_reg, id_call, id_jmpl;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_imm;
  logic [79:0] id_kw;

  logic [3:0]  ex_alu_op, ex_soh_s;
  logic        ex_alu_src, ex_psr_en, ex_rf_le, ex_load;
  logic [1:0]  ex_ram_size;
  logic        ex_ram_rw, ex_ram_en;
  logic [1:0]  ex_lcj;
  logic        ex_mem_to_reg, ex_call, ex_jmpl;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [31:0] ex_imm;
  logic [79:0] ex_kw;
  logic        mem_rf_le;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_ram_size;
  logic        mem_ram_rw, mem_ram_en, mem_load;
  logic [1:0]  mem_lcj;
  logic        mem_mem_to_reg;
  logic [79:0] mem_kw;
  logic        wb_rf_le;
  logic [4:0]  wb_rd;
  logic [1:0]  wb_lcj;
  logic        wb_mem_to_reg;
  logic [79:0] wb_kw;
  logic        stall_if;
  logic [15:0] cnt_retired, cnt_bubbles;

  int tests_run = 0;
  int tests_failed = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic le_seen = 1'b0;

  ctrl_pipe_regs dut (
    .clk(clk), .reset(reset), .LE(LE), .flush(flush),
    .id_alu_op(id_alu_op), .id_soh_s(id_soh_s), .id_alu_src(id_alu_src),
    .id_psr_en(id_psr_en), .id_rf_le(id_rf_le), .id_load(id_load),
    .id_ram_size(id_ram_size), .id_ram_rw(id_ram_rw), .id_ram_en(id_ram_en),
    .id_lcj(id_lcj), .id_mem_to_reg(id_mem_to_reg), .id_call(id_call), .id_jmpl(id_jmpl),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_imm(id_imm), .id_kw(id_kw),
    .ex_alu_op(ex_alu_op), .ex_soh_s(ex_soh_s), .ex_alu_src(ex_alu_src),
    .ex_psr_en(ex_psr_en), .ex_rf_le(ex_rf_le), .ex_load(ex_load),
    .ex_ram_size(ex_ram_size), .ex_ram_rw(ex_ram_rw), .ex_ram_en(ex_ram_en),
    .ex_lcj(ex_lcj), .ex_mem_to_reg(ex_mem_to_reg), .ex_call(ex_call), .ex_jmpl(ex_jmpl),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_imm(ex_imm), .ex_kw(ex_kw),
    .mem_rf_le(mem_rf_le), .mem_rd(mem_rd), .mem_ram_size(mem_ram_size),
    .mem_ram_rw(mem_ram_rw), .mem_ram_en(mem_ram_en), .mem_load(mem_load),
    .mem_lcj(mem_lcj), .mem_mem_to_reg(mem_mem_to_reg), .mem_kw(mem_kw),
    .wb_rf_le(wb_rf_le), .wb_rd(wb_rd), .wb_lcj(wb_lcj), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_kw(wb_kw), .stall_if(stall_if), .cnt_retired(cnt_retired), .cnt_bubbles(cnt_bubbles)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [79:0] kw, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic rf_le, input logic load,
                           input logic [1:0] lcj);
    id_kw = kw; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rf_le = rf_le; id_load = load; id_lcj = lcj;
    id_ram_en = load; id_ram_rw = 1'b0; id_mem_to_reg = load;
    id_alu_src = load; id_psr_en = 1'b0; id_alu_op = 4'h0; id_soh_s = 4'h0;
    id_ram_size = 2'b00; id_call = 1'b0; id_jmpl = 1'b0; id_imm = 32'h0;
  endtask

  // expected WB view: {kw, rd, rf_le after r0 masking, lcj, mem_to_reg}
  task automatic push_exp(input logic [79:0] kw, input logic [4:0] rd, input logic rf_le,
                          input logic [1:0] lcj, input logic m2r);
    exp_q.push_back({kw, rd, rf_le, lcj, m2r});
  endtask

  // scoreboard monitor: a non-nop word newly clocked into WB is an instruction to retire
  always @(posedge clk) le_seen <= LE & ~reset;

  always @(negedge clk) begin
    if (le_seen && wb_kw !== NOP) begin
      if (exp_q.size() == 0) begin
        chk("wb_unexpected", {wb_kw, wb_rd, wb_rf_le, wb_lcj, wb_mem_to_reg}, '0);
      end else begin
        chk("wb_word", {wb_kw, wb_rd, wb_rf_le, wb_lcj, wb_mem_to_reg}, exp_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1; LE = 1'b1; flush = 1'b0;
    set_instr(NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00);

    // reset
    step(); step();
    chk("rst_ex_kw", ex_kw, NOP);
    chk("rst_mem_kw", mem_kw, NOP);
    chk("rst_wb_kw", wb_kw, NOP);
    chk("rst_ex_rd", ex_rd, 0);
    chk("rst_wb_rf_le", wb_rf_le, 0);
    chk("rst_cnt_ret", cnt_retired, 0);
    chk("rst_cnt_bub", cnt_bubbles, 0);
    chk("rst_stall", stall_if, 0);
    reset = 1'b0;
    step();                                     // idle nop accepted

    // add r1,r2 -> r3 then subcc r3,r4 -> r6
    set_instr("add", 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 2'b00);
    #1 chk("add_stall", stall_if, 0);
    step(); push_exp("add", 5'd3, 1'b1, 2'b00, 1'b0);
    chk("add_ex_kw", ex_kw, 80'h616464);
    chk("add_ex_rd", ex_rd, 3);
    chk("add_ex_rs1", ex_rs1, 1);
    set_instr("subcc", 5'd3, 5'd4, 5'd6, 1'b1, 1'b0, 2'b00);
    id_psr_en = 1'b1;
    #1 chk("subcc_stall", stall_if, 0);
    step(); push_exp("subcc", 5'd6, 1'b1, 2'b00, 1'b0);
    chk("subcc_ex_psr", ex_psr_en, 1);
    chk("add_mem_rd", mem_rd, 3);

    // ldub -> r5 followed by a consumer of r5
    set_instr("ldub", 5'd2, 5'd0, 5'd5, 1'b1, 1'b1, 2'b01);
    step(); push_exp("ldub", 5'd5, 1'b1, 2'b01, 1'b1);
    chk("add_wb_rf_le", wb_rf_le, 1);
    chk("add_wb_rd", wb_rd, 3);
    set_instr("or", 5'd5, 5'd1, 5'd7, 1'b1, 1'b0, 2'b00);
    #1 chk("lu_stall", stall_if, 1);
    step();
    chk("lu_ex_kw", ex_kw, NOP);
    chk("lu_cnt_bub", cnt_bubbles, 1);
    chk("lu_stall_clear", stall_if, 0);
    step(); push_exp("or", 5'd7, 1'b1, 2'b00, 1'b0);
    chk("lu_ex_or", ex_kw, 80'h6f72);

    // ldub -> r0 then a consumer of r0: no stall
    set_instr("ldz", 5'd2, 5'd0, 5'd0, 1'b1, 1'b1, 2'b01);
    step(); push_exp("ldz", 5'd0, 1'b0, 2'b01, 1'b1);
    set_instr("add", 5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 2'b00);
    #1 chk("r0_stall", stall_if, 0);
    step(); push_exp("add", 5'd8, 1'b1, 2'b00, 1'b0);

    // flush while a hazard is active
    set_instr("ld", 5'd1, 5'd0, 5'd9, 1'b1, 1'b1, 2'b01);
    step(); push_exp("ld", 5'd9, 1'b1, 2'b01, 1'b1);
    set_instr("jmpl", 5'd9, 5'd0, 5'd15, 1'b1, 1'b0, 2'b11);
    flush = 1'b1;
    #1 chk("fl_stall", stall_if, 0);
    step();
    flush = 1'b0;
    chk("fl_ex_kw", ex_kw, NOP);
    chk("fl_cnt_bub", cnt_bubbles, 2);
    set_instr("sub", 5'd9, 5'd2, 5'd11, 1'b1, 1'b0, 2'b00);
    #1 chk("sub_stall", stall_if, 0);
    step(); push_exp("sub", 5'd11, 1'b1, 2'b00, 1'b0);

    // freeze three cycles
    LE = 1'b0;
    set_instr("xor", 5'd1, 5'd2, 5'd10, 1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("frz_ex_kw", ex_kw, 80'h737562);
      chk("frz_mem_kw", mem_kw, NOP);
      chk("frz_wb_rd", wb_rd, 9);
      chk("frz_cnt_ret", cnt_retired, 7);
      chk("frz_cnt_bub", cnt_bubbles, 2);
    end
    LE = 1'b1;
    step(); push_exp("xor", 5'd10, 1'b1, 2'b00, 1'b0);
    chk("res_ex_kw", ex_kw, 80'h786f72);
    chk("res_mem_kw", mem_kw, 80'h737562);

    // drain with flush bubbles
    flush = 1'b1;
    for (int i = 0; i < 4; i++) step();
    flush = 1'b0;
    @(negedge clk);
    chk("end_cnt_ret", cnt_retired, 10);
    chk("end_cnt_bub", cnt_bubbles, 6);
    chk("end_exp_left", exp_q.size(), 0);

    // reset asserted in the middle of a stall
    set_instr("ld", 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 2'b01);
    step();
    set_instr("and", 5'd5, 5'd1, 5'd12, 1'b1, 1'b0, 2'b00);
    #1 chk("rs_stall_before", stall_if, 1);
    reset = 1'b1;
    step();
    chk("rs_stall_after", stall_if, 0);
    chk("rs_ex_kw", ex_kw, NOP);
    chk("rs_cnt_ret", cnt_retired, 0);
    chk("rs_cnt_bub", cnt_bubbles, 0);
    reset = 1'b0;
    step();

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
